ibex_probe_ctrl: RTL and testbench
==================================

IBEX_PROBE_CTRL -- requirements
Module: ibex_probe_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 15: width of the fast-interrupt stimulus vector.
REQ-002 Parameter CNT_W, default 16: width of each event counter and of cmd_len.
REQ-003 Parameter FETCH_DLY, default 4: cycles from reset release to fetch_enable assertion.
REQ-004 Ports, in order:
  clk  in  1  clock; all state on the rising edge.
  rst_n  in  1  asynchronous active-low reset.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
  cmd_op  in  2  opcode: 0=DBG_PULSE, 1=IRQ_PULSE, 2=HALT, 3=RESUME.
  cmd_len  in  CNT_W  pulse length in cycles.
  cmd_idx  in  $clog2(NUM_IRQ)  interrupt line select.
  fetch_enable  out  1  to core.
  debug_req  out  1  to core.
  irq_fast  out  NUM_IRQ  to core.
  ecall, core_sleep, alert_minor, alert_major  in  1 each  from core.
  ecall_cnt, minor_cnt, major_cnt  out  CNT_W each  event counters.
  major_seen  out  1  sticky major alert.
  test_done  out  1  sticky first ecall.
  clr  in  1  synchronous clear of counters and sticky flags.

Function
REQ-005 FSM states: BOOT, IDLE, DBG_HOLD, IRQ_HOLD.
REQ-006 BOOT: count FETCH_DLY cycles after reset release, then go to IDLE and set fetch_enable=1; cmd_ready=0 in BOOT.
REQ-007 IDLE: cmd_ready=1; other states: cmd_ready=0.
REQ-008 DBG_PULSE accepted: next cycle debug_req=1, state DBG_HOLD; debug_req stays high for exactly max(cmd_len,1) cycles, then returns to 0 and the FSM returns to IDLE.
REQ-009 IRQ_PULSE accepted: irq_fast[cmd_idx]=1 for max(cmd_len,1) cycles, all other bits 0, via IRQ_HOLD; cmd_idx>=NUM_IRQ is accepted but drives no bit, still consuming the cycles.
REQ-010 HALT: fetch_enable=0 the cycle after acceptance; RESUME: fetch_enable=1 the cycle after acceptance; both stay in IDLE.
REQ-011 cmd_len and cmd_idx are captured at acceptance; later changes have no effect on a pulse in progress.
REQ-012 Counters increment on ecall, alert_minor, alert_major rising edges (previous-cycle sample 0, current 1) and saturate at 2^CNT_W-1.
REQ-013 major_seen is set on any alert_major rising edge; test_done is set on any ecall rising edge; both remain set until clr or reset.
REQ-014 clr zeroes all counters and sticky flags next cycle; a rising edge in the same cycle as clr is lost, with clr taking priority.
REQ-015 core_sleep is edge-sampled only; a rising edge of core_sleep while in DBG_HOLD or IRQ_HOLD does not cut the pulse short.
REQ-016 No output is combinationally dependent on any input.

Reset
REQ-017 On rst_n=0, asynchronously: state=BOOT, fetch_enable=0, debug_req=0, irq_fast=0, cmd_ready=0, all counters=0, major_seen=0, test_done=0, edge samples=0.
REQ-018 Reset asserted mid-pulse drops debug_req/irq_fast immediately; after release, the BOOT delay restarts.

Verification
REQ-019 Release reset with FETCH_DLY=4 -> fetch_enable rises on the 5th edge after release; cmd_ready=1 from the same cycle.
REQ-020 DBG_PULSE with cmd_len=3 -> debug_req high for exactly 3 cycles starting the cycle after acceptance; cmd_ready=0 for those 3 cycles; cmd_len=0 -> 1-cycle pulse.
REQ-021 IRQ_PULSE with cmd_idx=7 and cmd_len=2 -> irq_fast=15'h0080 for 2 cycles; cmd_idx=15 -> irq_fast stays 0 for 2 cycles.
REQ-022 HALT then RESUME back-to-back -> fetch_enable low for 1 cycle.
REQ-023 ecall held high for 10 cycles -> ecall_cnt=1 and test_done=1; with CNT_W=4 and 20 alert_minor edges, minor_cnt saturates at 15.
REQ-024 Assert rst_n=0 during a 100-cycle DBG_HOLD -> debug_req=0 in the same cycle; clr coincident with an alert_major edge -> major_seen=0 and major_cnt=0.

Source files
------------

// File: rtl/ibex_probe_ctrl_if.sv
// ibex_probe_ctrl_if
// Command channel into the probe controller. A command transfers on a rising
// clock edge when cmd_valid and cmd_ready are both high.
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  controller idle and able to take a command
//   cmd_op     master->slave  0=DBG_PULSE, 1=IRQ_PULSE, 2=HALT, 3=RESUME
//   cmd_len    master->slave  pulse length in cycles (0 behaves as 1)
//   cmd_idx    master->slave  fast-interrupt line select
interface ibex_probe_ctrl_if #(
   parameter int NUM_IRQ = 15,
   parameter int CNT_W   = 16
) ();
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [1:0]                 cmd_op;
   logic [CNT_W-1:0]           cmd_len;
   logic [$clog2(NUM_IRQ)-1:0] cmd_idx;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_len,
      output cmd_idx,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_len,
      input  cmd_idx,
      output cmd_ready
   );
endinterface

// File: rtl/ibex_probe_ctrl.sv
// ibex_probe_ctrl
// Stimulus and observation block wrapped around an Ibex core in a test
// harness. It holds the core's fetch off for FETCH_DLY cycles after reset,
// then accepts commands that pulse debug_req or one fast interrupt line, or
// halt/resume instruction fetch. It also counts rising edges of the core's
// ecall and alert outputs and keeps sticky flags for the first ecall and for
// any major alert.
//   clk, rst_n        clock and asynchronous active-low reset
//   cmd               command channel (slave side)
//   fetch_enable      fetch enable to the core
//   debug_req         debug request pulse to the core
//   irq_fast          fast interrupt lines to the core (one-hot while pulsing)
//   ecall, core_sleep, alert_minor, alert_major   status from the core
//   ecall_cnt, minor_cnt, major_cnt               saturating edge counters
//   major_seen, test_done                         sticky flags
//   clr               synchronous clear of counters and sticky flags
// Every output is taken straight from a register or decoded from the state
// register only, so no input reaches an output combinationally.
module ibex_probe_ctrl #(
   parameter int NUM_IRQ   = 15,
   parameter int CNT_W     = 16,
   parameter int FETCH_DLY = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   ibex_probe_ctrl_if.slave   cmd,
   output logic               fetch_enable,
   output logic               debug_req,
   output logic [NUM_IRQ-1:0] irq_fast,
   input  logic               ecall,
   input  logic               core_sleep,
   input  logic               alert_minor,
   input  logic               alert_major,
   output logic [CNT_W-1:0]   ecall_cnt,
   output logic [CNT_W-1:0]   minor_cnt,
   output logic [CNT_W-1:0]   major_cnt,
   output logic               major_seen,
   output logic               test_done,
   input  logic               clr
);

   localparam int IW = $clog2(NUM_IRQ);
   // One spare count value so FETCH_DLY itself is representable, even for 0.
   localparam int BW = $clog2(FETCH_DLY + 2);
   localparam logic [BW-1:0]    BOOT_LAST = BW'(FETCH_DLY);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   localparam logic [1:0] OP_DBG  = 2'd0;
   localparam logic [1:0] OP_IRQ  = 2'd1;
   localparam logic [1:0] OP_HALT = 2'd2;

   typedef enum logic [1:0] {
      BOOT,
      IDLE,
      DBG_HOLD,
      IRQ_HOLD
   } state_e;

   state_e           state_q, state_d;
   logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             fetch_q, fetch_d;
   logic [CNT_W-1:0] len_eff;

   logic ecall_q, minor_q, major_q, sleep_q;
   logic ecall_rise, minor_rise, major_rise;
   logic unused_sleep_rise;

   // A zero length still produces a one-cycle pulse.
   assign len_eff = (cmd.cmd_len == '0) ? ONE : cmd.cmd_len;

   assign cmd.cmd_ready = (state_q == IDLE);
   assign fetch_enable  = fetch_q;
   assign debug_req     = (state_q == DBG_HOLD);

   // State and captured command fields. Reset drops the pulse outputs at once
   // because they decode from state_q, and restarts the boot delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         boot_cnt_q <= '0;
         remain_q   <= '0;
         idx_q      <= '0;
         fetch_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         remain_q   <= remain_d;
         idx_q      <= idx_d;
         fetch_q    <= fetch_d;
      end
   end

   // Next-state logic. The hold states count the captured length down and
   // ignore everything on the command channel and from the core.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      remain_d   = remain_q;
      idx_d      = idx_q;
      fetch_d    = fetch_q;
      unique case (state_q)
         BOOT: begin
            if (boot_cnt_q == BOOT_LAST) begin
               state_d = IDLE;
               fetch_d = 1'b1;
            end else begin
               boot_cnt_d = boot_cnt_q + BW'(1);
            end
         end
         IDLE: begin
            if (cmd.cmd_valid) begin
               unique case (cmd.cmd_op)
                  OP_DBG: begin
                     state_d  = DBG_HOLD;
                     remain_d = len_eff;
                  end
                  OP_IRQ: begin
                     state_d  = IRQ_HOLD;
                     remain_d = len_eff;
                     idx_d    = cmd.cmd_idx;
                  end
                  OP_HALT: fetch_d = 1'b0;
                  default: fetch_d = 1'b1;
               endcase
            end
         end
         default: begin
            if (remain_q == ONE) begin
               state_d = IDLE;
            end else begin
               remain_d = remain_q - ONE;
            end
         end
      endcase
   end

   // One-hot interrupt decode; an index beyond the last line drives nothing.
   always_comb begin
      irq_fast = '0;
      if (state_q == IRQ_HOLD) begin
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (idx_q == IW'(i)) begin
               irq_fast[i] = 1'b1;
            end
         end
      end
   end

   assign ecall_rise        = ecall & ~ecall_q;
   assign minor_rise        = alert_minor & ~minor_q;
   assign major_rise        = alert_major & ~major_q;
   // core_sleep is sampled for edge detection but deliberately steers nothing.
   assign unused_sleep_rise = core_sleep & ~sleep_q;

   // Edge samples always track their inputs; clr wins over a same-cycle edge,
   // so that edge is lost rather than counted after the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ecall_q    <= 1'b0;
         minor_q    <= 1'b0;
         major_q    <= 1'b0;
         sleep_q    <= 1'b0;
         ecall_cnt  <= '0;
         minor_cnt  <= '0;
         major_cnt  <= '0;
         major_seen <= 1'b0;
         test_done  <= 1'b0;
      end else begin
         ecall_q <= ecall;
         minor_q <= alert_minor;
         major_q <= alert_major;
         sleep_q <= core_sleep;
         if (clr) begin
            ecall_cnt  <= '0;
            minor_cnt  <= '0;
            major_cnt  <= '0;
            major_seen <= 1'b0;
            test_done  <= 1'b0;
         end else begin
            if (ecall_rise) begin
               test_done <= 1'b1;
               if (ecall_cnt != CNT_MAX) ecall_cnt <= ecall_cnt + ONE;
            end
            if (minor_rise && (minor_cnt != CNT_MAX)) begin
               minor_cnt <= minor_cnt + ONE;
            end
            if (major_rise) begin
               major_seen <= 1'b1;
               if (major_cnt != CNT_MAX) major_cnt <= major_cnt + ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_ibex_probe_ctrl.sv
// tb_ibex_probe_ctrl
// Directed bench for ibex_probe_ctrl. A main instance (defaults) covers boot,
// the command table, handshake corner cases, event counters and reset; a
// second instance with 4-bit counters covers counter saturation.
module tb_ibex_probe_ctrl;

   logic clk;
   logic rst_n;

   logic        fetch_enable, debug_req;
   logic [14:0] irq_fast;
   logic        ecall, core_sleep, alert_minor, alert_major, clr;
   logic [15:0] ecall_cnt, minor_cnt, major_cnt;
   logic        major_seen, test_done;

   logic        fetch_enable2, debug_req2;
   logic [14:0] irq_fast2;
   logic        alert_minor2;
   logic [3:0]  ecall_cnt2, minor_cnt2, major_cnt2;
   logic        major_seen2, test_done2;

   int testsRun  = 0;
   int testsFail = 0;

   ibex_probe_ctrl_if #(.NUM_IRQ(15), .CNT_W(16)) bus ();
   ibex_probe_ctrl_if #(.NUM_IRQ(15), .CNT_W(4))  bus2 ();

   ibex_probe_ctrl #(.NUM_IRQ(15), .CNT_W(16), .FETCH_DLY(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd          (bus),
      .fetch_enable (fetch_enable),
      .debug_req    (debug_req),
      .irq_fast     (irq_fast),
      .ecall        (ecall),
      .core_sleep   (core_sleep),
      .alert_minor  (alert_minor),
      .alert_major  (alert_major),
      .ecall_cnt    (ecall_cnt),
      .minor_cnt    (minor_cnt),
      .major_cnt    (major_cnt),
      .major_seen   (major_seen),
      .test_done    (test_done),
      .clr          (clr)
   );

   ibex_probe_ctrl #(.NUM_IRQ(15), .CNT_W(4), .FETCH_DLY(4)) dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd          (bus2),
      .fetch_enable (fetch_enable2),
      .debug_req    (debug_req2),
      .irq_fast     (irq_fast2),
      .ecall        (1'b0),
      .core_sleep   (1'b0),
      .alert_minor  (alert_minor2),
      .alert_major  (1'b0),
      .ecall_cnt    (ecall_cnt2),
      .minor_cnt    (minor_cnt2),
      .major_cnt    (major_cnt2),
      .major_seen   (major_seen2),
      .test_done    (test_done2),
      .clr          (1'b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] len;
      logic [3:0]  idx;
      int          cycles;
      int          sleepAt;
      logic        expDbg;
      logic [14:0] expIrq;
      logic        expFetch;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Boot delay: fetch_enable and cmd_ready stay low for four edges after
   // release and both go high on the fifth.
   task automatic bootCheck();
      for (int i = 1; i <= 4; i++) begin
         step();
         checkOutput($sformatf("boot_fetch_e%0d", i), 32'(fetch_enable), 32'd0);
         checkOutput($sformatf("boot_ready_e%0d", i), 32'(bus.cmd_ready), 32'd0);
      end
      step();
      checkOutput("boot_fetch_e5", 32'(fetch_enable), 32'd1);
      checkOutput("boot_ready_e5", 32'(bus.cmd_ready), 32'd1);
   endtask

   // Offer one command, scramble len/idx right after acceptance, then follow
   // the pulse cycle by cycle and the return to IDLE.
   task automatic applyStimulus(input int n);
      vec_t v;
      v = vecs[n];
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = v.op;
      bus.cmd_len   = v.len;
      bus.cmd_idx   = v.idx;
      step();
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = 16'hffff;
      bus.cmd_idx   = 4'd3;
      for (int c = 0; c < v.cycles; c++) begin
         checkOutput($sformatf("v%0d_c%0d_dbg", n, c), 32'(debug_req), 32'(v.expDbg));
         checkOutput($sformatf("v%0d_c%0d_irq", n, c), 32'(irq_fast), 32'(v.expIrq));
         checkOutput($sformatf("v%0d_c%0d_ready", n, c), 32'(bus.cmd_ready), 32'd0);
         if (c == v.sleepAt) core_sleep = 1'b1;
         step();
      end
      core_sleep = 1'b0;
      checkOutput($sformatf("v%0d_end_dbg", n), 32'(debug_req), 32'd0);
      checkOutput($sformatf("v%0d_end_irq", n), 32'(irq_fast), 32'd0);
      checkOutput($sformatf("v%0d_end_ready", n), 32'(bus.cmd_ready), 32'd1);
      checkOutput($sformatf("v%0d_end_fetch", n), 32'(fetch_enable), 32'(v.expFetch));
      step();
   endtask

   initial begin
      //            op     len     idx   cyc sleep dbg   irq        fetch
      vecs[0] = '{2'd0, 16'd3,  4'd0,  3, -1, 1'b1, 15'h0000, 1'b1};
      vecs[1] = '{2'd0, 16'd0,  4'd0,  1, -1, 1'b1, 15'h0000, 1'b1};
      vecs[2] = '{2'd1, 16'd2,  4'd7,  2, -1, 1'b0, 15'h0080, 1'b1};
      vecs[3] = '{2'd1, 16'd2,  4'd15, 2, -1, 1'b0, 15'h0000, 1'b1};
      vecs[4] = '{2'd1, 16'd1,  4'd0,  1, -1, 1'b0, 15'h0001, 1'b1};
      vecs[5] = '{2'd1, 16'd0,  4'd14, 1, -1, 1'b0, 15'h4000, 1'b1};
      vecs[6] = '{2'd0, 16'd4,  4'd0,  4,  1, 1'b1, 15'h0000, 1'b1};
      vecs[7] = '{2'd2, 16'd9,  4'd0,  0, -1, 1'b0, 15'h0000, 1'b0};
      vecs[8] = '{2'd0, 16'd2,  4'd0,  2, -1, 1'b1, 15'h0000, 1'b0};
      vecs[9] = '{2'd3, 16'd9,  4'd0,  0, -1, 1'b0, 15'h0000, 1'b1};

      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_len = 16'd0; bus.cmd_idx = 4'd0;
      bus2.cmd_valid = 1'b0; bus2.cmd_op = 2'd0; bus2.cmd_len = 4'd0; bus2.cmd_idx = 4'd0;
      ecall = 1'b0; core_sleep = 1'b0; alert_minor = 1'b0; alert_major = 1'b0;
      clr = 1'b0; alert_minor2 = 1'b0;

      step();
      step();
      checkOutput("rst_fetch", 32'(fetch_enable), 32'd0);
      checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("rst_dbg", 32'(debug_req), 32'd0);
      checkOutput("rst_irq", 32'(irq_fast), 32'd0);
      checkOutput("rst_ecall_cnt", 32'(ecall_cnt), 32'd0);
      checkOutput("rst_flags", 32'({major_seen, test_done}), 32'd0);

      rst_n = 1'b1;
      bootCheck();

      for (int n = 0; n < 10; n++) applyStimulus(n);

      // HALT immediately followed by RESUME: exactly one low cycle.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd2;
      step();
      checkOutput("halt_fetch", 32'(fetch_enable), 32'd0);
      checkOutput("halt_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_op = 2'd3;
      step();
      bus.cmd_valid = 1'b0;
      checkOutput("resume_fetch", 32'(fetch_enable), 32'd1);

      // ecall held for ten cycles is a single edge.
      ecall = 1'b1;
      for (int i = 0; i < 10; i++) step();
      ecall = 1'b0;
      step();
      checkOutput("ecall_cnt", 32'(ecall_cnt), 32'd1);
      checkOutput("test_done", 32'(test_done), 32'd1);

      for (int i = 0; i < 3; i++) begin
         alert_minor = 1'b1; step();
         alert_minor = 1'b0; step();
      end
      checkOutput("minor_cnt3", 32'(minor_cnt), 32'd3);
      alert_major = 1'b1; step();
      alert_major = 1'b0; step();
      checkOutput("major_cnt1", 32'(major_cnt), 32'd1);
      checkOutput("major_seen1", 32'(major_seen), 32'd1);

      clr = 1'b1; step();
      clr = 1'b0;
      checkOutput("clr_ecall_cnt", 32'(ecall_cnt), 32'd0);
      checkOutput("clr_minor_cnt", 32'(minor_cnt), 32'd0);
      checkOutput("clr_major_cnt", 32'(major_cnt), 32'd0);
      checkOutput("clr_flags", 32'({major_seen, test_done}), 32'd0);

      // clr in the same cycle as a major edge: the edge is lost for good.
      alert_major = 1'b1; clr = 1'b1; step();
      clr = 1'b0;
      checkOutput("clr_edge_cnt", 32'(major_cnt), 32'd0);
      checkOutput("clr_edge_seen", 32'(major_seen), 32'd0);
      step();
      checkOutput("clr_edge_cnt_late", 32'(major_cnt), 32'd0);
      checkOutput("clr_edge_seen_late", 32'(major_seen), 32'd0);
      alert_major = 1'b0;
      step();

      // Saturation on the 4-bit instance.
      for (int i = 0; i < 20; i++) begin
         alert_minor2 = 1'b1; step();
         alert_minor2 = 1'b0; step();
      end
      checkOutput("sat_minor_cnt", 32'(minor_cnt2), 32'd15);
      checkOutput("sat_major_cnt", 32'(major_cnt2), 32'd0);

      // Reset in the middle of a long debug pulse.
      ecall = 1'b1; step();
      ecall = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_len = 16'd100;
      step();
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checkOutput("long_dbg_high", 32'(debug_req), 32'd1);
      rst_n = 1'b0;
      #2;
      checkOutput("rst_mid_dbg", 32'(debug_req), 32'd0);
      checkOutput("rst_mid_fetch", 32'(fetch_enable), 32'd0);
      checkOutput("rst_mid_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("rst_mid_done", 32'(test_done), 32'd0);
      step();
      rst_n = 1'b1;
      bootCheck();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
